// File: rtl/shift_pkg.sv
// Shared types for the multi-step shift sequencer: FSM states, shift command
// encoding and direction constants.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        CMD_LOG   = 2'b00,
        CMD_ARITH = 2'b01,
        CMD_ROT   = 2'b10,
        CMD_PASS  = 2'b11
    } shift_cmd_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shifter: logical, arithmetic or rotate by one
// position in either direction, or pass-through.
module shift_step
    import shift_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         dir,
    input  logic [1:0]   cmd,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = din;
        case (shift_cmd_t'(cmd))
            CMD_LOG: begin
                if (dir == DIR_RIGHT) dout = {1'b0, din[W-1:1]};
                else                  dout = {din[W-2:0], 1'b0};
            end
            CMD_ARITH: begin
                // Arithmetic left is identical to logical left.
                if (dir == DIR_RIGHT) dout = {din[W-1], din[W-1:1]};
                else                  dout = {din[W-2:0], 1'b0};
            end
            CMD_ROT: begin
                if (dir == DIR_RIGHT) dout = {din[0], din[W-1:1]};
                else                  dout = {din[W-2:0], din[W-1]};
            end
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-step shift controller: accepts a request, applies a one-bit shift
// `count` times (one step per clock) and returns the result over valid/ready.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int W  = 6,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_dir,
    input  logic [1:0]    in_cmd,
    input  logic [W-1:0]  in_data,
    input  logic [CW-1:0] in_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          busy
);

    seq_state_t    state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [W-1:0]  step_data;

    shift_step #(.W(W)) u_step (
        .dir  (dir_q),
        .cmd  (cmd_q),
        .din  (data_q),
        .dout (step_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            cmd_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        cmd_d     = cmd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = in_count;
                    dir_d   = in_dir;
                    cmd_d   = in_cmd;
                    state_d = (in_count == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // Only entered with cnt_q >= 1, so the decrement never wraps.
                data_d = step_data;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data = out_valid ? data_q : '0;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against an arithmetic
// reference model of the multi-step shift.
module tb_shift_sequencer;

    localparam int W  = 6;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_dir;
    logic [1:0]    in_cmd;
    logic [W-1:0]  in_data;
    logic [CW-1:0] in_count;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dir    (in_dir),
        .in_cmd    (in_cmd),
        .in_data   (in_data),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Whole-shift reference: computes the N-step result directly.
    function automatic logic [W-1:0] model(input logic dir, input logic [1:0] cmd,
                                           input logic [W-1:0] d, input int n);
        logic [31:0]         wide;
        logic signed [W-1:0] sd;
        logic [2*W-1:0]      dbl;
        int                  k;
        model = d;
        case (cmd)
            2'b00, 2'b01: begin
                if (dir == 1'b0) begin
                    wide  = 32'(d) << n;
                    model = wide[W-1:0];
                end else if (cmd == 2'b00) begin
                    model = d >> n;
                end else begin
                    sd    = d;
                    model = sd >>> n;
                end
            end
            2'b10: begin
                k = n % W;
                if (dir == 1'b0) begin
                    dbl   = {d, d} << k;
                    model = dbl[2*W-1:W];
                end else begin
                    dbl   = {d, d} >> k;
                    model = dbl[W-1:0];
                end
            end
            default: model = d;
        endcase
    endfunction

    // Present a request at a negedge while IDLE, then wait for the result.
    // Returns the number of clocks from the accepting edge to out_valid.
    task automatic send(input logic dir, input logic [1:0] cmd, input logic [W-1:0] d,
                        input int n, output int lat);
        in_valid = 1'b1;
        in_dir   = dir;
        in_cmd   = cmd;
        in_data  = d;
        in_count = CW'(n);
        check("accept_ready", int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        lat = 1;
        while (!out_valid && lat < 40) begin
            check("busy_shift", int'(busy), 1);
            check("no_ready_shift", int'(in_ready), 0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    // Hold the result for `stall` cycles, then consume it.
    task automatic consume(input int stall, input logic [W-1:0] exp);
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_data", int'(out_data), int'(exp));
            check("stall_inrdy", int'(in_ready), 0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_valid", int'(out_valid), 0);
        check("post_busy", int'(busy), 0);
    endtask

    task automatic do_req(input string tag, input logic dir, input logic [1:0] cmd,
                          input logic [W-1:0] d, input int n, input int stall);
        int           lat;
        logic [W-1:0] exp;
        exp       = model(dir, cmd, d, n);
        out_ready = (stall == 0);
        send(dir, cmd, d, n, lat);
        check({tag, "_lat"}, lat, n + 1);
        check({tag, "_data"}, int'(out_data), int'(exp));
        check({tag, "_busy"}, int'(busy), 1);
        consume(stall, exp);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] r;
        rst = 1'b1; in_valid = 1'b0; in_dir = 1'b0; in_cmd = 2'b00;
        in_data = '0; in_count = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_inrdy", int'(in_ready), 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);

        // Directed cases, expected values written out by hand.
        check("m_rotl", int'(model(1'b0, 2'b10, 6'b100101, 2)), int'(6'b010110));
        do_req("rotl2", 1'b0, 2'b10, 6'b100101, 2, 0);
        check("m_asr", int'(model(1'b1, 2'b01, 6'b101000, 3)), int'(6'b111101));
        do_req("asr3", 1'b1, 2'b01, 6'b101000, 3, 0);
        do_req("lsr7", 1'b1, 2'b00, 6'b111111, 7, 0);
        check("m_lsr7", int'(model(1'b1, 2'b00, 6'b111111, 7)), 0);
        do_req("rotr6", 1'b1, 2'b10, 6'b000001, 6, 0);
        check("m_rotr6", int'(model(1'b1, 2'b10, 6'b000001, 6)), 1);
        do_req("cnt0", 1'b0, 2'b00, 6'b011011, 0, 0);
        do_req("pass5", 1'b1, 2'b11, 6'b011011, 5, 0);

        // Backpressure with a competing request pending during the stall.
        out_ready = 1'b0;
        send(1'b0, 2'b10, 6'b100000, 1, lat);
        check("bp_lat", lat, 2);
        check("bp_data", int'(out_data), int'(6'b000001));
        in_valid = 1'b1; in_dir = 1'b1; in_cmd = 2'b00; in_data = 6'b110000; in_count = 3'd2;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_hold", int'(out_data), int'(6'b000001));
            check("bp_inrdy", int'(in_ready), 0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_valid", int'(out_valid), 0);
        send(1'b1, 2'b00, 6'b110000, 2, lat);
        check("bp2_lat", lat, 3);
        check("bp2_data", int'(out_data), int'(6'b001100));
        consume(0, 6'b001100);

        // Reset on the second SHIFT cycle of a count=5 request.
        out_ready = 1'b1;
        in_valid = 1'b1; in_dir = 1'b0; in_cmd = 2'b00; in_data = 6'b000111; in_count = 3'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("rm_busy1", int'(busy), 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rm_inrdy", int'(in_ready), 1);
        check("rm_valid", int'(out_valid), 0);
        check("rm_data", int'(out_data), 0);
        check("rm_busy", int'(busy), 0);
        do_req("after_rst", 1'b0, 2'b01, 6'b010011, 4, 1);

        // Randomized requests with random backpressure.
        for (int t = 0; t < 60; t++) begin
            r = W'($urandom);
            do_req("rand", 1'($urandom), 2'($urandom), r,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
